// File: rtl/alien_bullet_pool.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alien_bullet_pool: pool of alien bullet slots with queued fire, per-frame |
// | movement, per-slot kill and a registered RGB render.                      |
// | Optional aiming drift: define ALIEN_BULLET_AIM_EN.                        |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module alien_bullet_pool #(
   parameter int          NUM_BULLETS   = 4,
   parameter int          SPEED         = 4,
   parameter int          VRES          = 480,
   parameter int          HRES          = 640,
   parameter int          BULLET_W      = 4,
   parameter int          BULLET_H      = 8,
   parameter int          FIRE_COOLDOWN = 2,
   parameter logic [23:0] COLOR         = 24'hFF4040,
   parameter int          DRIFT         = 1,
   localparam int         c_idx_w       = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1,
   localparam int         c_cnt_w       = $clog2(NUM_BULLETS + 1)
) (
   input  logic                      pixel_clk,
   input  logic                      rst,
   input  logic                      fsync,
   input  logic                      fire,
   input  logic signed [11:0]        fire_x,
   input  logic signed [11:0]        fire_y,
   input  logic signed [11:0]        player_x,
   input  logic                      hit_valid,
   input  logic [c_idx_w-1:0]        hit_idx,
   input  logic signed [11:0]        hpos,
   input  logic signed [11:0]        vpos,
   output logic                      fire_ack,
   output logic [NUM_BULLETS-1:0]    active_mask,
   output logic [c_cnt_w-1:0]        in_flight,
   output logic                      pixel_hit,
   output logic [7:0]                pixel [0:2]
);

   localparam int                 c_cd_w    = $clog2(FIRE_COOLDOWN + 2);
   localparam logic [c_cd_w-1:0]  c_cooldown = c_cd_w'(FIRE_COOLDOWN);
   localparam logic signed [11:0] c_vlimit  = 12'(VRES - SPEED);
   localparam logic signed [11:0] c_speed   = 12'(SPEED);
   localparam logic signed [11:0] c_half    = 12'(BULLET_W / 2);
   localparam logic signed [11:0] c_height  = 12'(BULLET_H);

   logic                     r_pending;
   logic signed [11:0]       r_fire_x;
   logic signed [11:0]       r_fire_y;
   logic [c_cd_w-1:0]        r_cooldown;
   logic                     r_fire_ack;
   logic                     r_pixel_hit;
   logic [23:0]              r_rgb;

   logic [NUM_BULLETS-1:0]   w_active;
   logic [NUM_BULLETS-1:0]   w_cover;
   logic                     w_free_any;
   logic [c_idx_w-1:0]       w_free_idx;
   logic                     w_launch;

   // Descending scan so the lowest free index is the last one written.
   always_comb begin
      w_free_any = 1'b0;
      w_free_idx = '0;
      for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
         if (!w_active[i]) begin
            w_free_any = 1'b1;
            w_free_idx = c_idx_w'(i);
         end
      end
   end

   assign w_launch = fsync && r_pending && (r_cooldown == '0) && w_free_any;

   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         r_pending  <= 1'b0;
         r_fire_x   <= '0;
         r_fire_y   <= '0;
         r_cooldown <= '0;
         r_fire_ack <= 1'b0;
      end else begin
         r_fire_ack <= w_launch;
         if (w_launch) begin
            r_pending  <= 1'b0;
            r_cooldown <= c_cooldown;
         end else begin
            if (fire && !r_pending) begin
               r_pending <= 1'b1;
               r_fire_x  <= fire_x;
               r_fire_y  <= fire_y;
            end
            if (fsync && (r_cooldown != '0))
               r_cooldown <= r_cooldown - 1'b1;
         end
      end
   end

   for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
      logic               r_active;
      logic signed [11:0] r_x;
      logic signed [11:0] r_y;
      logic               w_kill;
      logic               w_load;
      logic signed [11:0] w_x_next;

      assign w_kill = hit_valid && (hit_idx == c_idx_w'(i));
      assign w_load = w_launch && (w_free_idx == c_idx_w'(i));

`ifdef ALIEN_BULLET_AIM_EN
      logic               r_dir_pos;
      logic               r_dir_neg;
      logic signed [12:0] w_aim_diff;
      logic signed [13:0] w_x_sum;
      localparam logic signed [13:0] c_drift = 14'(DRIFT);
      localparam logic signed [13:0] c_xmax  = 14'(HRES - 1);

      assign w_aim_diff = 13'(player_x) - 13'(r_fire_x);
      assign w_x_sum    = 14'(r_x) + (r_dir_pos ? c_drift : (r_dir_neg ? -c_drift : 14'sd0));

      always_comb begin
         if (w_x_sum < 0)
            w_x_next = '0;
         else if (w_x_sum > c_xmax)
            w_x_next = 12'(c_xmax);
         else
            w_x_next = w_x_sum[11:0];
      end

      always_ff @(posedge pixel_clk) begin
         if (rst) begin
            r_dir_pos <= 1'b0;
            r_dir_neg <= 1'b0;
         end else if (w_load) begin
            r_dir_pos <= (w_aim_diff > 0);
            r_dir_neg <= (w_aim_diff < 0);
         end
      end
`else
      assign w_x_next = r_x;
`endif

      // A load only targets an inactive slot, and a kill only matters on an active one.
      always_ff @(posedge pixel_clk) begin
         if (rst) begin
            r_active <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
         end else if (w_load) begin
            r_active <= 1'b1;
            r_x      <= r_fire_x;
            r_y      <= r_fire_y;
         end else if (r_active && w_kill) begin
            r_active <= 1'b0;
         end else if (fsync && r_active) begin
            if (r_y < c_vlimit) begin
               r_y <= r_y + c_speed;
               r_x <= w_x_next;
            end else begin
               r_active <= 1'b0;
            end
         end
      end

      assign w_active[i] = r_active;
      assign w_cover[i]  = r_active
                           && (hpos >= r_x - c_half) && (hpos <= r_x + c_half)
                           && (vpos >= r_y) && (vpos <= r_y + c_height);
   end

`ifndef ALIEN_BULLET_AIM_EN
   logic w_unused_player_x;
   assign w_unused_player_x = &{1'b0, player_x};
`endif

   always_comb begin
      in_flight = '0;
      for (int i = 0; i < NUM_BULLETS; i++)
         in_flight = in_flight + c_cnt_w'(w_active[i]);
   end

   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         r_pixel_hit <= 1'b0;
         r_rgb       <= '0;
      end else begin
         r_pixel_hit <= |w_cover;
         r_rgb       <= (|w_cover) ? COLOR : 24'h000000;
      end
   end

   assign fire_ack    = r_fire_ack;
   assign active_mask = w_active;
   assign pixel_hit   = r_pixel_hit;
   assign pixel[2]    = r_rgb[23:16];
   assign pixel[1]    = r_rgb[15:8];
   assign pixel[0]    = r_rgb[7:0];

endmodule
`default_nettype wire

// File: tb/tb_alien_bullet_pool.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alien_bullet_pool: randomized bench with reference model and an ack   |
// | scoreboard for alien_bullet_pool (default build).                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_alien_bullet_pool;

   localparam int NB    = 4;
   localparam int SPEED = 4;
   localparam int VRES  = 480;
   localparam int HALF  = 2;
   localparam int H     = 8;
   localparam int COOL  = 2;

   logic              pixel_clk = 1'b0;
   logic              rst, fsync, fire, hit_valid;
   logic signed [11:0] fire_x, fire_y, player_x, hpos, vpos;
   logic [1:0]        hit_idx;
   logic              fire_ack;
   logic [NB-1:0]     active_mask;
   logic [2:0]        in_flight;
   logic              pixel_hit;
   logic [7:0]        pixel [0:2];

   alien_bullet_pool #(.NUM_BULLETS(NB), .SPEED(SPEED), .VRES(VRES), .HRES(640),
                       .BULLET_W(4), .BULLET_H(H), .FIRE_COOLDOWN(COOL),
                       .COLOR(24'hFF4040), .DRIFT(1)) dut (
      .pixel_clk(pixel_clk), .rst(rst), .fsync(fsync), .fire(fire),
      .fire_x(fire_x), .fire_y(fire_y), .player_x(player_x),
      .hit_valid(hit_valid), .hit_idx(hit_idx), .hpos(hpos), .vpos(vpos),
      .fire_ack(fire_ack), .active_mask(active_mask), .in_flight(in_flight),
      .pixel_hit(pixel_hit), .pixel(pixel)
   );

   always #5 pixel_clk = ~pixel_clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Reference model: bullets as plain integer positions.
   bit m_act [NB];
   int m_x [NB];
   int m_y [NB];
   bit m_pend;
   int m_px, m_py, m_cd;
   bit exp_hit;

   typedef struct { int cyc; logic [NB-1:0] mask; } ack_t;
   ack_t ack_q [$];

   function automatic logic [NB-1:0] m_mask();
      logic [NB-1:0] m = '0;
      for (int i = 0; i < NB; i++) m[i] = m_act[i];
      return m;
   endfunction

   function automatic int m_count();
      int n = 0;
      for (int i = 0; i < NB; i++) n += int'(m_act[i]);
      return n;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic model_step();
      bit pend0;
      int slot;
      if (rst) begin
         for (int i = 0; i < NB; i++) begin m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; end
         m_pend = 0; m_cd = 0; exp_hit = 0;
         return;
      end
      exp_hit = 0;
      for (int i = 0; i < NB; i++)
         if (m_act[i] && int'(hpos) >= m_x[i] - HALF && int'(hpos) <= m_x[i] + HALF &&
             int'(vpos) >= m_y[i] && int'(vpos) <= m_y[i] + H)
            exp_hit = 1;
      pend0 = m_pend;
      if (fsync) begin
         slot = -1;
         if (m_pend && m_cd == 0)
            for (int i = 0; i < NB; i++)
               if (!m_act[i]) begin slot = i; break; end
         for (int i = 0; i < NB; i++)
            if (m_act[i]) begin
               if (hit_valid && int'(hit_idx) == i) m_act[i] = 0;
               else if (m_y[i] < VRES - SPEED) m_y[i] += SPEED;
               else m_act[i] = 0;
            end
         if (slot >= 0) begin
            m_act[slot] = 1; m_x[slot] = m_px; m_y[slot] = m_py;
            m_pend = 0; m_cd = COOL;
            ack_q.push_back('{cyc: cyc, mask: m_mask()});
         end else if (m_cd > 0) begin
            m_cd--;
         end
      end else if (hit_valid && int'(hit_idx) < NB) begin
         m_act[hit_idx] = 0;
      end
      if (fire && !pend0) begin
         m_pend = 1; m_px = int'(fire_x); m_py = int'(fire_y);
      end
   endtask

   task automatic tick();
      @(posedge pixel_clk);
      cyc++;
      model_step();
      @(negedge pixel_clk);
      chk("active_mask", 32'(active_mask), 32'(m_mask()));
      chk("in_flight", 32'(in_flight), 32'(m_count()));
      chk("pixel_hit", 32'(pixel_hit), 32'(exp_hit));
      chk("pixel", {8'h00, pixel[2], pixel[1], pixel[0]}, exp_hit ? 32'hFF4040 : 32'h0);
      fsync = 0; fire = 0; hit_valid = 0;
   endtask

   // Scoreboard monitor: every fire_ack must match a predicted launch, in time and mask.
   always @(negedge pixel_clk) begin
      ack_t e;
      while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
         checks++; errors++;
         e = ack_q.pop_front();
         $display("FAIL fire_ack missing: got 0 expected 1 at cycle %0d", e.cyc);
      end
      if (fire_ack === 1'b1) begin
         checks++;
         if (ack_q.size() == 0) begin
            errors++;
            $display("FAIL fire_ack unexpected: got 1 expected 0 at cycle %0d", cyc);
         end else begin
            e = ack_q.pop_front();
            if (e.cyc != cyc || e.mask !== active_mask) begin
               errors++;
               $display("FAIL fire_ack launch: got cycle %0d mask %b expected cycle %0d mask %b",
                        cyc, active_mask, e.cyc, e.mask);
            end
         end
      end
   end

   task automatic probe_random();
      int s;
      s = $urandom_range(0, NB - 1);
      if (m_act[s] && $urandom_range(0, 3) != 0) begin
         hpos = 12'(m_x[s] + $urandom_range(0, 6) - 3);
         vpos = 12'(m_y[s] + $urandom_range(0, 12) - 2);
      end else begin
         hpos = 12'($urandom_range(0, 639));
         vpos = 12'($urandom_range(0, 479));
      end
   endtask

   int probe_tab [6][3] = '{'{100, 58, 1}, '{100, 57, 0}, '{102, 66, 1},
                            '{103, 60, 0}, '{98, 66, 1}, '{100, 67, 0}};

   initial begin
      rst = 1; fsync = 0; fire = 0; hit_valid = 0; hit_idx = 0;
      fire_x = 0; fire_y = 0; player_x = 0; hpos = 0; vpos = 0;
      repeat (3) tick();
      chk("reset fire_ack", 32'(fire_ack), 32'h0);
      chk("reset mask", 32'(active_mask), 32'h0);
      rst = 0;
      tick();

      // First launch and two frames of movement: 50 -> 58.
      fire = 1; fire_x = 100; fire_y = 50; tick();
      tick(); tick();
      fsync = 1; tick();
      chk("first launch mask", 32'(active_mask), 32'h1);
      chk("first launch ack", 32'(fire_ack), 32'h1);
      repeat (2) begin tick(); fsync = 1; tick(); end
      for (int i = 0; i < 6; i++) begin
         hpos = 12'(probe_tab[i][0]); vpos = 12'(probe_tab[i][1]);
         tick();
         chk("render box", 32'(pixel_hit), 32'(probe_tab[i][2]));
      end

      // Bottom-edge retirement plus cooldown pacing with a saturated pool.
      fire = 1; fire_x = 200; fire_y = 470; tick();
      for (int f = 0; f < 14; f++) begin
         fire = 1; fire_x = 12'(300 + f); fire_y = 12'(10 * f);
         tick();
         fsync = 1; fire = 1; tick();
      end
      chk("pool full", 32'(active_mask), 32'hF);

      // Kill coincident with fsync, then a kill while idle.
      hit_valid = 1; hit_idx = 1; fsync = 1; tick();
      tick();
      hit_valid = 1; hit_idx = 2; tick();

      // Randomized frames with one mid-run reset.
      for (int f = 0; f < 300; f++) begin
         if (f == 150) begin rst = 1; tick(); tick(); rst = 0; end
         fsync = 1;
         for (int c = 0; c < int'($urandom_range(3, 7)); c++) begin
            if ($urandom_range(0, 2) == 0) begin
               fire = 1;
               fire_x = 12'($urandom_range(0, 639));
               fire_y = 12'($urandom_range(0, 479));
            end
            if ($urandom_range(0, 7) == 0) begin
               hit_valid = 1;
               hit_idx = 2'($urandom_range(0, 3));
            end
            player_x = 12'($urandom_range(0, 639));
            probe_random();
            tick();
         end
      end

      repeat (3) tick();
      chk("ack queue drained", 32'(ack_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
